uart_tx_stream_arbiter: RTL
===========================

// Module: uart_tx_stream_arbiter
// PURPOSE
//  Shares the single UART TX byte channel between Main_FSM command replies and
//  the ADC capture FIFO readout stream. ADC bytes are wrapped in frames:
//  header, payload, end marker, 16-bit byte count. Reply bytes are buffered and
//  never interleaved into a frame. Sits between Main_FSM/DataStorageAcc and TxDWrapper.
// PARAMETERS
//  HDR_BYTE    8'hA5  first byte of every ADC frame
//  EOD_BYTE    8'hFF  end-of-data marker after the payload
//  CMD_AW      4      command FIFO address width (depth 2**CMD_AW = 16)
//  MAX_FRAME   4096   payload bytes per frame before a forced close (1..65535)
// PORTS
//  clk        in   1   system clock (main 100 MHz domain)
//  Reset_n    in   1   synchronous reset, active low
//  cmd_data   in   8   reply byte from Main_FSM
//  cmd_wr     in   1   one-cycle write strobe for cmd_data
//  cmd_full   out  1   command FIFO full
//  cmd_ovf    out  1   sticky: cmd_wr seen while full; cleared only by reset
//  adc_data   in   8   FIFO read data, valid 1 cycle after adc_rd
//  adc_ready  in   1   ADC FIFO holds at least one byte
//  adc_rd     out  1   one-cycle FIFO read strobe
//  tx_data    out  8   byte to TxDWrapper
//  tx_wr      out  1   one-cycle send strobe
//  tx_busy    in   1   TxDWrapper busy; rises within 1 cycle of tx_wr
//  in_frame   out  1   high from HDR issue until CNT_LO issued
//  state      out  4   FSM state encoding, for debug/LEDs
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, byte count 0, cmd_ovf 0.
//  Send rule: tx_wr is pulsed only when tx_busy=0 and not in GUARD. Every tx_wr
//   is followed by exactly one GUARD cycle in which tx_busy is ignored.
//   tx_data is held until the next tx_wr.
//  FSM states: IDLE, CMD, HDR, ADC_RD, ADC_LAT, ADC_TX, EOD, CNT_HI, CNT_LO, GUARD.
//   IDLE: a non-empty cmd FIFO goes to CMD (replies have priority). Else if
//    adc_ready, go to HDR. Else stay.
//   CMD: pop one byte and send it, then return to IDLE via GUARD.
//   HDR: send HDR_BYTE, clear the count, set in_frame, then go to ADC_RD.
//   ADC_RD: if adc_ready and count<MAX_FRAME, pulse adc_rd and go to ADC_LAT.
//    Otherwise go to EOD.
//   ADC_LAT: capture adc_data and go to ADC_TX.
//   ADC_TX: send the byte, count+1, then go to ADC_RD.
//   EOD: send EOD_BYTE. CNT_HI: send count[15:8]. CNT_LO: send count[7:0],
//    clear in_frame, then go to IDLE.
//  Latency: replies from IDLE with tx_busy=0 reach tx_wr 2 cycles after cmd_wr.
//  Count is 16 bits and never wraps; MAX_FRAME<=65535 bounds it.
//  Frames hitting MAX_FRAME close normally. A new frame starts from IDLE only
//   after pending replies have drained.
//  adc_ready dropping mid-frame: the current byte completes, then EOD.
//  An empty frame is impossible: HDR is entered only with adc_ready=1.
//  cmd_wr with FIFO full: the byte is dropped and cmd_ovf set. cmd_wr in the
//   same cycle as a CMD pop is accepted even when full.
//  Reset_n low mid-frame: abort immediately; no EOD or count is sent. The FIFO
//   contents are lost.
//  adc_rd never asserts outside ADC_RD, and at most once per 3 cycles.
// STRUCTURE
//  Shared package fda_tx_pkg: state enum, HDR_BYTE/EOD_BYTE defaults, COUNT_W=16.
//  Sub-module tx_cmd_fifo: synchronous FWFT FIFO, width 8, depth 2**CMD_AW,
//   with full/empty flags. The FSM, count and guard logic stay in this module.
// TESTING (TxD model: busy for 10 cycles after tx_wr; FIFO model: 1-cycle read latency)
//  1. cmd_wr 8'h4F then 8'h4B, no ADC data -> tx bytes 4F,4B; in_frame stays 0.
//  2. adc_ready for 3 bytes 11,22,33 -> tx A5,11,22,33,FF,00,03; 3 adc_rd pulses.
//  3. cmd_wr 8'h21 mid-frame of 2 bytes -> A5,b0,b1,FF,00,02,21; no interleave.
//  4. MAX_FRAME=4, 6 bytes queued -> frame of 4 (count 00,04), then frame of 2.
//  5. 17 cmd_wr with tx_busy held 1 -> cmd_full after 16, cmd_ovf=1, 16 bytes out.
//  6. Reset_n low for 1 cycle after the 2nd payload byte -> no further tx_wr;
//     all outputs 0; a fresh frame starts A5 when adc_ready.

Source files
------------

// File: rtl/fda_tx_pkg.sv
// Shared definitions for the UART TX stream arbiter.
//   tx_state_t       FSM state encoding; the raw value is also exported on the
//                    arbiter's 4-bit state port for debug/LEDs.
//   COUNT_W          width of the per-frame payload byte counter.
//   HDR/EOD defaults first byte of every ADC frame / end-of-data marker.
//   after_send()     state the FSM resumes in once the GUARD cycle that
//                    follows each transmitted byte has elapsed.
package fda_tx_pkg;

    localparam int unsigned COUNT_W          = 16;
    localparam logic [7:0]  HDR_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0]  EOD_BYTE_DEFAULT = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD     = 4'd1,
        ST_HDR     = 4'd2,
        ST_ADC_RD  = 4'd3,
        ST_ADC_LAT = 4'd4,
        ST_ADC_TX  = 4'd5,
        ST_EOD     = 4'd6,
        ST_CNT_HI  = 4'd7,
        ST_CNT_LO  = 4'd8,
        ST_GUARD   = 4'd9
    } tx_state_t;

    // Successor of a byte-sending state, taken after its GUARD cycle.
    function automatic tx_state_t after_send(input tx_state_t s);
        tx_state_t r;
        case (s)
            ST_CMD:    r = ST_IDLE;
            ST_HDR:    r = ST_ADC_RD;
            ST_ADC_TX: r = ST_ADC_RD;
            ST_EOD:    r = ST_CNT_HI;
            ST_CNT_HI: r = ST_CNT_LO;
            ST_CNT_LO: r = ST_IDLE;
            default:   r = ST_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tx_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO buffering Main_FSM reply bytes.
//   clk      system clock
//   Reset_n  synchronous reset, active low; empties the FIFO
//   wr_data  byte to store
//   wr_en    write request; honoured when not full, or when full and a read
//            happens in the same cycle
//   rd_en    pop the head entry (ignored while empty)
//   rd_data  head entry, valid whenever empty is low
//   full     2**AW entries held
//   empty    no entries held
module tx_cmd_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned LW    = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          do_wr;
    logic          do_rd;

    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    // Storage is deliberately not reset; the level counter defines validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/uart_tx_stream_arbiter.sv
// Shares one UART TX byte channel between Main_FSM command replies and the
// ADC capture FIFO readout. ADC bytes go out as frames
//   HDR_BYTE, payload..., EOD_BYTE, count[15:8], count[7:0]
// and reply bytes wait in a small FIFO, never interleaved into a frame.
// Replies win arbitration in IDLE; a frame closes early at MAX_FRAME bytes.
//   clk        system clock
//   Reset_n    synchronous reset, active low; aborts any frame in progress
//   cmd_data   reply byte from Main_FSM
//   cmd_wr     one-cycle write strobe for cmd_data
//   cmd_full   command FIFO full
//   cmd_ovf    sticky: cmd_wr dropped because the FIFO was full
//   adc_data   ADC FIFO read data, valid one cycle after adc_rd
//   adc_ready  ADC FIFO holds at least one byte
//   adc_rd     one-cycle ADC FIFO read strobe
//   tx_data    byte to TxDWrapper, held until the next tx_wr
//   tx_wr      one-cycle send strobe
//   tx_busy    TxDWrapper busy
//   in_frame   ADC frame in progress (header sent, count not yet finished)
//   state      FSM state encoding for debug/LEDs
module uart_tx_stream_arbiter
    import fda_tx_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE  = HDR_BYTE_DEFAULT,
    parameter logic [7:0]  EOD_BYTE  = EOD_BYTE_DEFAULT,
    parameter int unsigned CMD_AW    = 4,
    parameter int unsigned MAX_FRAME = 4096
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic [7:0] cmd_data,
    input  logic       cmd_wr,
    output logic       cmd_full,
    output logic       cmd_ovf,
    input  logic [7:0] adc_data,
    input  logic       adc_ready,
    output logic       adc_rd,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    output logic       in_frame,
    output logic [3:0] state
);

    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_FRAME);

    tx_state_t          state_q;
    tx_state_t          state_d;
    tx_state_t          ret_q;
    tx_state_t          ret_d;
    logic [COUNT_W-1:0] count_q;
    logic [7:0]         adc_byte_q;
    logic [7:0]         tx_data_q;
    logic               in_frame_q;
    logic               cmd_ovf_q;

    logic               send_state;
    logic [7:0]         send_byte;
    logic               below_max;
    logic               cmd_pop;
    logic [7:0]         fifo_data;
    logic               fifo_full;
    logic               fifo_empty;

    tx_cmd_fifo #(
        .AW (CMD_AW),
        .DW (8)
    ) u_cmd_fifo (
        .clk     (clk),
        .Reset_n (Reset_n),
        .wr_data (cmd_data),
        .wr_en   (cmd_wr),
        .rd_en   (cmd_pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign below_max = (count_q < MAX_COUNT);
    assign cmd_pop   = tx_wr && (state_q == ST_CMD);

    // State register
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    // Next-state logic. Every sending state waits for tx_busy low, fires once,
    // then passes through GUARD (tx_busy ignored) before its successor.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_CMD;
                end else if (adc_ready) begin
                    state_d = ST_HDR;
                end
            end
            ST_ADC_RD: begin
                state_d = (adc_ready && below_max) ? ST_ADC_LAT : ST_EOD;
            end
            ST_ADC_LAT: begin
                state_d = ST_ADC_TX;
            end
            ST_GUARD: begin
                state_d = ret_q;
            end
            default: begin
                if (tx_wr) begin
                    state_d = ST_GUARD;
                    ret_d   = after_send(state_q);
                end
            end
        endcase
    end

    // Output logic. tx_wr is combinational so a reply leaves two cycles after
    // its cmd_wr; tx_data shows the outgoing byte on that cycle and the
    // registered copy afterwards.
    always_comb begin
        send_state = 1'b0;
        send_byte  = '0;
        adc_rd     = 1'b0;
        case (state_q)
            ST_CMD: begin
                send_state = 1'b1;
                send_byte  = fifo_data;
            end
            ST_HDR: begin
                send_state = 1'b1;
                send_byte  = HDR_BYTE;
            end
            ST_ADC_TX: begin
                send_state = 1'b1;
                send_byte  = adc_byte_q;
            end
            ST_EOD: begin
                send_state = 1'b1;
                send_byte  = EOD_BYTE;
            end
            ST_CNT_HI: begin
                send_state = 1'b1;
                send_byte  = count_q[COUNT_W-1:8];
            end
            ST_CNT_LO: begin
                send_state = 1'b1;
                send_byte  = count_q[7:0];
            end
            ST_ADC_RD: begin
                adc_rd = adc_ready && below_max;
            end
            default: ;
        endcase
        tx_wr   = send_state && !tx_busy;
        tx_data = tx_wr ? send_byte : tx_data_q;
    end

    // Datapath: held tx byte, captured ADC byte, frame count and flags.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            tx_data_q  <= '0;
            adc_byte_q <= '0;
            count_q    <= '0;
            in_frame_q <= 1'b0;
            cmd_ovf_q  <= 1'b0;
        end else begin
            if (tx_wr) begin
                tx_data_q <= send_byte;
            end
            if (state_q == ST_ADC_LAT) begin
                adc_byte_q <= adc_data;
            end
            if (tx_wr && (state_q == ST_HDR)) begin
                count_q    <= '0;
                in_frame_q <= 1'b1;
            end else if (tx_wr && (state_q == ST_ADC_TX)) begin
                count_q <= count_q + COUNT_W'(1);
            end
            if (tx_wr && (state_q == ST_CNT_LO)) begin
                in_frame_q <= 1'b0;
            end
            if (cmd_wr && fifo_full && !cmd_pop) begin
                cmd_ovf_q <= 1'b1;
            end
        end
    end

    assign cmd_full = fifo_full;
    assign cmd_ovf  = cmd_ovf_q;
    assign in_frame = in_frame_q;
    assign state    = state_q;

endmodule
